fetch_unit: RTL and testbench

//   Instruction-fetch stage. Owns the PC and the instruction-memory request handshake.

---
 rtl/fetch_unit.sv | 85 ++++++++
 tb/tb_fetch_unit.sv | 96 +++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and instruction-memory handshake for the fetch stage
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        pc_src_d,
  input  logic [31:0] branch_target_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_f,
  output logic [31:0] pc_plus_4_f,
  output logic        valid_f,
  output logic        fetch_busy
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;
  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] instr_buf_q, instr_buf_d;
  logic [31:0] pc_inc, next_pc;
  logic        redir, in_fetch, hit;
  assign pc_inc   = fetch_pc_q + 32'd4;
  assign redir    = pc_src_d & ~stall_f;
  assign next_pc  = pc_src_d ? branch_target_d : pc_inc;
  assign in_fetch = state_q == FETCH;
  assign hit      = in_fetch & imem_ready;
  // Next-state: advance PC on delivery, park stalled words, remember redirects while a request is in flight
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redirect_pc_d = redirect_pc_q;
    instr_buf_d   = instr_buf_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH:
        if (imem_ready) begin
          if (!stall_f) fetch_pc_d = next_pc;
          else begin
            instr_buf_d = imem_rdata;
            state_d     = HOLD;
          end
        end else if (redir) begin
          redirect_pc_d = branch_target_d;
          state_d       = DISCARD;
        end
      HOLD:
        if (!stall_f) begin
          fetch_pc_d = next_pc;
          state_d    = FETCH;
        end
      DISCARD: begin
        if (redir) redirect_pc_d = branch_target_d;
        if (imem_ready) begin
          fetch_pc_d = redir ? branch_target_d : redirect_pc_q;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State registers; reset abandons any in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      redirect_pc_q <= 32'd0;
      instr_buf_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redirect_pc_q <= redirect_pc_d;
      instr_buf_q   <= instr_buf_d;
    end
  end
  assign imem_req    = in_fetch | (state_q == DISCARD);
  assign imem_addr   = fetch_pc_q;
  assign valid_f     = hit | (state_q == HOLD);
  assign instr_f     = hit ? imem_rdata : (state_q == HOLD) ? instr_buf_q : 32'd0;
  assign pc_plus_4_f = valid_f ? pc_inc : 32'd0;
  assign fetch_busy  = (in_fetch & ~imem_ready) | (state_q == DISCARD);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed-vector check of fetch_unit handshake, stall, redirect and reset
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_f = 1'b0;
  logic        pc_src_d = 1'b0;
  logic [31:0] branch_target_d = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr_f;
  logic [31:0] pc_plus_4_f;
  logic        valid_f;
  logic        fetch_busy;
  int          n_tests = 0;
  int          n_fail = 0;
  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .pc_src_d(pc_src_d),
    .branch_target_d(branch_target_d), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_f(instr_f),
    .pc_plus_4_f(pc_plus_4_f), .valid_f(valid_f), .fetch_busy(fetch_busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic outs(input string tag, input bit e_req, input logic [31:0] e_addr,
                      input bit e_valid, input logic [31:0] e_instr,
                      input logic [31:0] e_pc4, input bit e_busy);
    check({tag, ".req"},   {31'd0, imem_req},   {31'd0, e_req});
    check({tag, ".addr"},  imem_addr,           e_addr);
    check({tag, ".valid"}, {31'd0, valid_f},    {31'd0, e_valid});
    check({tag, ".instr"}, instr_f,             e_instr);
    check({tag, ".pc4"},   pc_plus_4_f,         e_pc4);
    check({tag, ".busy"},  {31'd0, fetch_busy}, {31'd0, e_busy});
  endtask
  task automatic step(input string tag, input bit st, input bit src, input logic [31:0] tgt,
                      input bit rdy, input logic [31:0] rd,
                      input bit e_req, input logic [31:0] e_addr, input bit e_valid,
                      input logic [31:0] e_instr, input logic [31:0] e_pc4, input bit e_busy);
    stall_f = st; pc_src_d = src; branch_target_d = tgt; imem_ready = rdy; imem_rdata = rd;
    #3;
    outs(tag, e_req, e_addr, e_valid, e_instr, e_pc4, e_busy);
    @(posedge clk); #1;
  endtask
  initial begin
    #2;
    outs("rst", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("idle", 0, 0, 32'h0, 1, 32'h1111_1111, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    step("f0",   0, 0, 32'h0, 1, 32'h1000_0000, 1, 32'h0, 1, 32'h1000_0000, 32'h4, 0);
    step("f4",   0, 0, 32'h0, 1, 32'h1000_0004, 1, 32'h4, 1, 32'h1000_0004, 32'h8, 0);
    step("w8a",  0, 0, 32'h0, 0, 32'h5555_5555, 1, 32'h8, 0, 32'h0, 32'h0, 1);
    step("w8b",  0, 0, 32'h0, 0, 32'h5555_5555, 1, 32'h8, 0, 32'h0, 32'h0, 1);
    step("f8",   0, 0, 32'h0, 1, 32'h1000_0008, 1, 32'h8, 1, 32'h1000_0008, 32'hC, 0);
    step("fC",   0, 0, 32'h0, 1, 32'h1000_000C, 1, 32'hC, 1, 32'h1000_000C, 32'h10, 0);
    step("s10",  1, 0, 32'h0, 1, 32'h2402_0005, 1, 32'h10, 1, 32'h2402_0005, 32'h14, 0);
    step("h1",   1, 0, 32'h0, 1, 32'hFFFF_FFFF, 0, 32'h10, 1, 32'h2402_0005, 32'h14, 0);
    step("h2",   1, 0, 32'h0, 1, 32'hFFFF_FFFF, 0, 32'h10, 1, 32'h2402_0005, 32'h14, 0);
    step("h3",   0, 0, 32'h0, 1, 32'hFFFF_FFFF, 0, 32'h10, 1, 32'h2402_0005, 32'h14, 0);
    step("f14",  0, 0, 32'h0, 1, 32'h1000_0014, 1, 32'h14, 1, 32'h1000_0014, 32'h18, 0);
    step("f18",  0, 0, 32'h0, 1, 32'h1000_0018, 1, 32'h18, 1, 32'h1000_0018, 32'h1C, 0);
    step("f1C",  0, 0, 32'h0, 1, 32'h1000_001C, 1, 32'h1C, 1, 32'h1000_001C, 32'h20, 0);
    step("r20",  0, 1, 32'h40, 0, 32'h0, 1, 32'h20, 0, 32'h0, 32'h0, 1);
    step("d20a", 0, 0, 32'h0, 0, 32'h0, 1, 32'h20, 0, 32'h0, 32'h0, 1);
    step("d20b", 0, 0, 32'h0, 1, 32'hDEAD_BEEF, 1, 32'h20, 0, 32'h0, 32'h0, 1);
    step("s40",  1, 1, 32'h80, 1, 32'h1000_0040, 1, 32'h40, 1, 32'h1000_0040, 32'h44, 0);
    step("h40",  0, 0, 32'h0, 1, 32'h0, 0, 32'h40, 1, 32'h1000_0040, 32'h44, 0);
    step("r44",  0, 1, 32'h100, 0, 32'h0, 1, 32'h44, 0, 32'h0, 32'h0, 1);
    step("d44a", 0, 1, 32'h200, 0, 32'h0, 1, 32'h44, 0, 32'h0, 32'h0, 1);
    step("d44b", 1, 1, 32'h700, 0, 32'h0, 1, 32'h44, 0, 32'h0, 32'h0, 1);
    step("d44c", 0, 0, 32'h0, 1, 32'hDEAD_BEEF, 1, 32'h44, 0, 32'h0, 32'h0, 1);
    step("f200", 0, 1, 32'h300, 1, 32'h1000_0200, 1, 32'h200, 1, 32'h1000_0200, 32'h204, 0);
    step("r300", 0, 1, 32'h500, 0, 32'h0, 1, 32'h300, 0, 32'h0, 32'h0, 1);
    step("d300", 0, 1, 32'h600, 1, 32'hDEAD_BEEF, 1, 32'h300, 0, 32'h0, 32'h0, 1);
    step("w600", 0, 0, 32'h0, 0, 32'h0, 1, 32'h600, 0, 32'h0, 32'h0, 1);
    stall_f = 1'b0; pc_src_d = 1'b0; imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    outs("rstmid", 0, 32'h0, 0, 32'h0, 32'h0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("idle2", 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    step("f0b",  0, 1, 32'hFFFF_FFFC, 1, 32'h1000_0000, 1, 32'h0, 1, 32'h1000_0000, 32'h4, 0);
    step("fwrap", 0, 0, 32'h0, 1, 32'h1FFF_FFFC, 1, 32'hFFFF_FFFC, 1, 32'h1FFF_FFFC, 32'h0, 0);
    step("f0c",  0, 0, 32'h0, 0, 32'h0, 1, 32'h0, 0, 32'h0, 32'h0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
